// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver that tracks the held state of a few configurable keys
// and queues press/release events in a small first-word-fall-through FIFO.
module ps2_key_tracker #(
  parameter int                      NUM_KEYS       = 5,
  parameter logic [9*NUM_KEYS-1:0]   KEY_CODES      = {9'h029, 9'h174, 9'h16B, 9'h172, 9'h175},
  parameter int                      FIFO_DEPTH     = 4,
  parameter int                      TIMEOUT_CYCLES = 5000,
  parameter int                      SYNC_STAGES    = 3,
  localparam int                     IDX_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                PS2_clk,
  input  logic                PS2_data,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDX_W-1:0]    evt_key,
  output logic                evt_press,
  output logic                err_parity,
  output logic                err_frame,
  output logic                overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {DEC_IDLE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   ps2_bit;

  logic [3:0]             bit_cnt;
  logic [9:0]             shift;
  logic [TW-1:0]          idle_cnt;
  logic                   timeout_hit;
  logic                   byte_valid;
  logic [7:0]             rx_byte;

  dec_state_t             dec_state;
  logic                   is_code;
  logic                   code_ext;
  logic                   code_brk;
  logic [8:0]             code;
  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic                   push_req;

  logic [IDX_W:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;
  logic [AW:0]            count;
  logic                   full;
  logic                   pop;
  logic                   do_push;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], PS2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall        = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign ps2_bit     = data_sync[SYNC_STAGES-1];
  assign timeout_hit = !fall && (bit_cnt != 4'd0) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // After ten shifts the start bit sits in shift[0]; the stop bit is the live sample.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bit_cnt    <= 4'd0;
      shift      <= '0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= 8'h00;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (shift[0] || !ps2_bit) begin
            err_frame <= 1'b1;
          end else if (!(^shift[9:1])) begin
            err_parity <= 1'b1;
          end else begin
            byte_valid <= 1'b1;
            rx_byte    <= shift[8:1];
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shift   <= {ps2_bit, shift[9:1]};
        end
      end else if (timeout_hit) begin
        err_frame <= 1'b1;
        bit_cnt   <= 4'd0;
        idle_cnt  <= '0;
      end else if (bit_cnt != 4'd0) begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dec_state <= DEC_IDLE;
    end else if (timeout_hit) begin
      dec_state <= DEC_IDLE;
    end else if (byte_valid) begin
      case (rx_byte)
        8'hE0: begin
          if (dec_state == DEC_IDLE)     dec_state <= DEC_EXT;
          else if (dec_state == DEC_BRK) dec_state <= DEC_EXT_BRK;
        end
        8'hF0: begin
          if (dec_state == DEC_IDLE)     dec_state <= DEC_BRK;
          else if (dec_state == DEC_EXT) dec_state <= DEC_EXT_BRK;
        end
        default: dec_state <= DEC_IDLE;
      endcase
    end
  end

  assign is_code  = byte_valid && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
  assign code_ext = (dec_state == DEC_EXT) || (dec_state == DEC_EXT_BRK);
  assign code_brk = (dec_state == DEC_BRK) || (dec_state == DEC_EXT_BRK);
  assign code     = {code_ext, rx_byte};

  // Scan downwards so the lowest matching table entry wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[9*i +: 9] == code) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign push_req  = is_code && hit && (code_brk == key_state[hit_idx]);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = evt_valid && evt_ready;
  assign do_push   = push_req && (!full || pop);
  assign evt_valid = (count != '0);
  assign {evt_key, evt_press} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {hit_idx, ~code_brk};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      key_state <= '0;
    end else begin
      if (push_req) key_state[hit_idx] <= ~code_brk;
      if (push_req && !do_push) overflow <= 1'b1;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter NUM_KEYS, default 5: number of tracked keys.
REQ-002 Parameter KEY_CODES, default {9'h029,9'h174,9'h16B,9'h172,9'h175}: packed 9-bit codes, entry i at [9*i+:9]; bit8 = E0-extended. Index 0 = up (E0 75), 1 = down (E0 72), 2 = left (E0 6B), 3 = right (E0 74), 4 = space (29).
REQ-003 Parameter FIFO_DEPTH, default 4: event FIFO depth, power of two, >= 2.
REQ-004 Parameter TIMEOUT_CYCLES, default 5000: maximum clk cycles between PS2_clk falling edges inside one frame.
REQ-005 Parameter SYNC_STAGES, default 3: synchroniser depth on PS2_clk and PS2_data, >= 2.
REQ-006 clk  in  1  system clock; the only clock in the block.
REQ-007 rstn  in  1  reset, synchronous, active-low.
REQ-008 PS2_clk  in  1  PS/2 clock, asynchronous to clk.
REQ-009 PS2_data  in  1  PS/2 data, asynchronous to clk.
REQ-010 key_state  out  NUM_KEYS  level per key; 1 = held.
REQ-011 evt_valid  out  1  event FIFO non-empty.
REQ-012 evt_ready  in  1  consumer accepts the head event.
REQ-013 evt_key  out  IDX_W = max(1,clog2(NUM_KEYS))  key index of the head event.
REQ-014 evt_press  out  1  head event type; 1 = press, 0 = release.
REQ-015 err_parity  out  1  one-cycle pulse on a parity failure.
REQ-016 err_frame  out  1  one-cycle pulse on a bad start bit, bad stop bit or timeout.
REQ-017 overflow  out  1  sticky; an event was dropped because the FIFO was full.

Function
REQ-018 PS2_clk and PS2_data SHALL pass through SYNC_STAGES flops each; a falling edge is synchronised-PS2_clk going 1->0 between consecutive clk cycles.
REQ-019 Each falling edge SHALL sample synchronised PS2_data into an 11-bit frame: start (0), data[0..7] LSB first, odd parity, stop (1).
REQ-020 On the 11th sample, the frame SHALL be accepted only if start=0, stop=1 and the XOR of data and parity is 1.
REQ-021 A parity failure SHALL pulse err_parity and discard the byte; a start or stop failure SHALL pulse err_frame and discard the byte.
REQ-022 Mid-frame (bit count 1..10), TIMEOUT_CYCLES clk cycles without a falling edge SHALL pulse err_frame, clear the bit count and return the decoder to DEC_IDLE.
REQ-023 The decoder FSM SHALL have states DEC_IDLE, DEC_EXT, DEC_BRK and DEC_EXT_BRK.
REQ-024 Decoder transitions on an accepted byte: E0 moves IDLE->EXT and BRK->EXT_BRK; F0 moves IDLE->BRK and EXT->EXT_BRK.
REQ-025 Any other accepted byte SHALL form code {ext, byte} with ext=1 in EXT or EXT_BRK, and break=1 in BRK or EXT_BRK, then return to DEC_IDLE.
REQ-026 Both E0 F0 xx and F0 E0 xx SHALL decode as an extended release.
REQ-027 E0 received in EXT or EXT_BRK, or F0 received in BRK or EXT_BRK, SHALL leave the state unchanged.
REQ-028 A code matching KEY_CODES entry i with break=0 and key_state[i]=0 SHALL set key_state[i] and push event {i, press=1}.
REQ-029 A code matching entry i with break=1 and key_state[i]=1 SHALL clear key_state[i] and push event {i, press=0}.
REQ-030 A repeated make on a held key (typematic), a break on a released key, or an unmapped code SHALL cause no state change and no event.
REQ-031 Latency: key_state and the FIFO write SHALL become visible exactly 2 clk cycles after the cycle in which the stop-bit falling edge is detected.
REQ-032 The FIFO SHALL be first-word-fall-through; evt_valid=1 iff non-empty; evt_key and evt_press SHALL stay stable while evt_valid=1 and evt_ready=0.
REQ-033 A pop SHALL occur when evt_valid=1 and evt_ready=1; evt_ready while empty SHALL have no effect.
REQ-034 Push while full without a simultaneous pop SHALL drop the event, set overflow and still update key_state.
REQ-035 Push and pop in the same cycle SHALL both succeed at any occupancy, including full.
REQ-036 Multiple keys SHALL be held simultaneously, with each bit of key_state independent.

Reset
REQ-037 With rstn=0 at a rising clk edge, the block SHALL clear key_state, evt_valid, err_parity, err_frame and overflow to 0, empty the FIFO, zero the bit count and timeout counter, set the decoder to DEC_IDLE and preset the synchronisers to 1.
REQ-038 Reset asserted mid-frame SHALL discard the partial frame; the next frame SHALL decode normally after rstn returns to 1.

Verification
REQ-039 Frame 29 -> key_state=5'b10000, event {4, press}; then F0 29 -> key_state=0, event {4, release}.
REQ-040 E0 75, E0 6B, then F0 E0 75 -> events {0,press}, {2,press}, {0,release}; final key_state=5'b00100.
REQ-041 Byte 29 sent with even parity -> err_parity pulses once, key_state and FIFO unchanged; a following good 29 -> press event.
REQ-042 Stop after 5 data bits, then hold PS2_clk high for TIMEOUT_CYCLES -> one err_frame pulse; the next frame decodes correctly.
REQ-043 evt_ready=0 with 5 distinct key changes -> 4 events queued in order, overflow=1 and key_state reflects all 5 changes; drain -> evt_valid falls after the 4th pop.
REQ-044 29 sent three times (typematic) -> exactly one press event; E0 7A (unmapped) -> no event.
